// File: rtl/rob_multi_if.sv
// Dispatch, completion, flush and retirement signals of the reorder buffer.
// The master side dispatches and completes; the slave side is the buffer itself.
interface rob_multi_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned RET_W  = 2,
  parameter int unsigned PREG_W = 7
);
  localparam int unsigned TAG_W = $clog2(DEPTH);

  logic                      alloc_valid;
  logic                      alloc_ready;
  logic                      alloc_has_rd;
  logic [PREG_W-1:0]         alloc_pd_old;
  logic [TAG_W-1:0]          alloc_tag;

  logic [NUM_CH-1:0]         cmpl_valid;
  logic [NUM_CH*TAG_W-1:0]   cmpl_tag;

  logic                      mispredict;
  logic [TAG_W-1:0]          mispredict_tag;

  logic [RET_W-1:0]          retire_valid;
  logic [RET_W*TAG_W-1:0]    retire_tag;
  logic [RET_W*PREG_W-1:0]   retire_pd_old;
  logic [RET_W-1:0]          retire_has_rd;

  logic [TAG_W:0]            count;
  logic                      empty;

  modport master (
    output alloc_valid, alloc_has_rd, alloc_pd_old,
    output cmpl_valid, cmpl_tag,
    output mispredict, mispredict_tag,
    input  alloc_ready, alloc_tag,
    input  retire_valid, retire_tag, retire_pd_old, retire_has_rd,
    input  count, empty
  );

  modport slave (
    input  alloc_valid, alloc_has_rd, alloc_pd_old,
    input  cmpl_valid, cmpl_tag,
    input  mispredict, mispredict_tag,
    output alloc_ready, alloc_tag,
    output retire_valid, retire_tag, retire_pd_old, retire_has_rd,
    output count, empty
  );
endinterface

// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocate, out-of-order multi-channel completion,
// in-order retirement of up to RET_W entries per cycle, and branch-flush truncation.
module rob_multi #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned RET_W  = 2,
  parameter int unsigned PREG_W = 7
) (
  input  logic       clk,
  input  logic       reset,
  rob_multi_if.slave rob
);
  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = TAG_W + 1;

  // Pointers carry a wrap bit above the index bits.
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  has_rd_q;
  logic [PREG_W-1:0] pd_old_q [DEPTH];

  logic [RET_W-1:0]        ret_valid_q;
  logic [RET_W*TAG_W-1:0]  ret_tag_q;
  logic [RET_W*PREG_W-1:0] ret_pd_old_q;
  logic [RET_W-1:0]        ret_has_rd_q;

  logic [TAG_W-1:0]  head_idx;
  logic [TAG_W-1:0]  tail_idx;
  logic [PTR_W-1:0]  count_c;
  logic              full;
  logic              alloc_ready_c;
  logic              alloc_fire;

  logic              flush_en;
  logic [TAG_W-1:0]  flush_dist;
  logic [PTR_W-1:0]  flush_tail;
  logic [DEPTH-1:0]  flush_kill;

  logic [RET_W-1:0]  ret_slot;
  logic [TAG_W-1:0]  ret_idx [RET_W];
  logic [PTR_W-1:0]  ret_cnt;
  logic              ret_run;

  logic [TAG_W-1:0]  cmpl_idx [NUM_CH];
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  done_d;

  assign head_idx      = head_q[TAG_W-1:0];
  assign tail_idx      = tail_q[TAG_W-1:0];
  assign count_c       = tail_q - head_q;
  assign full          = (count_c == PTR_W'(DEPTH));
  assign alloc_ready_c = !full && !rob.mispredict;
  assign alloc_fire    = rob.alloc_valid && alloc_ready_c;

  // Flush keeps the branch and everything older; the new tail sits just past the branch.
  always_comb begin
    flush_dist = rob.mispredict_tag - head_idx;
    flush_en   = rob.mispredict && valid_q[rob.mispredict_tag] &&
                 (rob.mispredict_tag != TAG_W'(tail_idx - TAG_W'(1)));
    flush_tail = head_q + PTR_W'(flush_dist) + PTR_W'(1);
    flush_kill = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (TAG_W'(TAG_W'(j) - head_idx) > flush_dist) begin
        flush_kill[j] = flush_en;
      end
    end
  end

  // Retire scan over registered state; stops at the first entry not ready and never
  // passes a branch that is being flushed this cycle.
  always_comb begin
    ret_run  = 1'b1;
    ret_cnt  = '0;
    ret_slot = '0;
    for (int s = 0; s < RET_W; s++) begin
      ret_idx[s] = head_idx + TAG_W'(s);
      if (ret_run && valid_q[ret_idx[s]] && done_q[ret_idx[s]] &&
          !(flush_en && (TAG_W'(s) > flush_dist))) begin
        ret_slot[s] = 1'b1;
        ret_cnt     = ret_cnt + PTR_W'(1);
      end else begin
        ret_run = 1'b0;
      end
    end
  end

  // Next valid/done: retire, then completion, then flush, then alloc.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int s = 0; s < RET_W; s++) begin
      if (ret_slot[s]) begin
        valid_d[ret_idx[s]] = 1'b0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      cmpl_idx[c] = rob.cmpl_tag[c*TAG_W +: TAG_W];
      if (rob.cmpl_valid[c] && valid_q[cmpl_idx[c]]) begin
        done_d[cmpl_idx[c]] = 1'b1;
      end
    end
    valid_d = valid_d & ~flush_kill;
    done_d  = done_d & ~flush_kill;
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      done_q       <= '0;
      has_rd_q     <= '0;
      ret_valid_q  <= '0;
      ret_tag_q    <= '0;
      ret_pd_old_q <= '0;
      ret_has_rd_q <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        pd_old_q[j] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_q + ret_cnt;
      tail_q  <= flush_en ? flush_tail : tail_q + PTR_W'(alloc_fire);
      for (int s = 0; s < RET_W; s++) begin
        ret_valid_q[s]                    <= ret_slot[s];
        ret_tag_q[s*TAG_W +: TAG_W]       <= ret_slot[s] ? ret_idx[s] : '0;
        ret_pd_old_q[s*PREG_W +: PREG_W]  <= ret_slot[s] ? pd_old_q[ret_idx[s]] : '0;
        ret_has_rd_q[s]                   <= ret_slot[s] & has_rd_q[ret_idx[s]];
      end
      if (alloc_fire) begin
        has_rd_q[tail_idx] <= rob.alloc_has_rd;
        pd_old_q[tail_idx] <= rob.alloc_pd_old;
      end
    end
  end

  assign rob.alloc_ready   = alloc_ready_c;
  assign rob.alloc_tag     = tail_idx;
  assign rob.count         = count_c;
  assign rob.empty         = (count_c == '0);
  assign rob.retire_valid  = ret_valid_q;
  assign rob.retire_tag    = ret_tag_q;
  assign rob.retire_pd_old = ret_pd_old_q;
  assign rob.retire_has_rd = ret_has_rd_q;

endmodule

// File: tb/tb_rob_multi.sv
// Scoreboard bench for rob_multi: the driver keeps an in-flight model queue,
// the negedge monitor pops it on every retirement and checks count/empty.
module tb_rob_multi;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned RET_W  = 2;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned TAG_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_multi_if #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .RET_W(RET_W), .PREG_W(PREG_W)) rob_if ();

  rob_multi #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .RET_W(RET_W), .PREG_W(PREG_W)) dut (
    .clk   (clk),
    .reset (rst),
    .rob   (rob_if)
  );

  typedef struct {
    int tag;
    int pd;
    int hrd;
    bit done;
    int rdy;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_tail = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Retirements must arrive in allocation order, with matching payload, no earlier
  // than two edges after the completion was presented.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (mon_en) begin
      for (int s = 0; s < RET_W; s++) begin
        if (rob_if.retire_valid[s]) begin
          if (s > 0) chk("retire_slot_order", int'(rob_if.retire_valid[s-1]), 1);
          if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL retire_unexpected: slot %0d tag %0d with empty scoreboard",
                     s, rob_if.retire_tag[s*TAG_W +: TAG_W]);
          end else begin
            e = mq.pop_front();
            chk("retire_tag", int'(rob_if.retire_tag[s*TAG_W +: TAG_W]), e.tag);
            chk("retire_pd_old", int'(rob_if.retire_pd_old[s*PREG_W +: PREG_W]), e.pd);
            chk("retire_has_rd", int'(rob_if.retire_has_rd[s]), e.hrd);
            chk("retire_when_ready", int'(e.done && (cyc >= e.rdy)), 1);
          end
        end
      end
      chk("count", int'(rob_if.count), mq.size());
      chk("empty", int'(rob_if.empty), int'(mq.size() == 0));
    end
  end

  function automatic logic [11:0] pk(input int a, input int b, input int c);
    return {4'(c), 4'(b), 4'(a)};
  endfunction

  // Apply one cycle of stimulus; the model is updated before the edge it describes.
  task automatic step(input bit av, input bit hrd, input int pd, input logic [2:0] cv,
                      input logic [11:0] ct, input bit mp, input int mt);
    int pos;
    int t;
    bit rdy;
    rob_if.alloc_valid    = av;
    rob_if.alloc_has_rd   = hrd;
    rob_if.alloc_pd_old   = 7'(pd);
    rob_if.cmpl_valid     = cv;
    rob_if.cmpl_tag       = ct;
    rob_if.mispredict     = mp;
    rob_if.mispredict_tag = 4'(mt);
    #1;
    rdy = (mq.size() < int'(DEPTH)) && !mp;
    chk("alloc_ready", int'(rob_if.alloc_ready), int'(rdy));
    for (int c = 0; c < NUM_CH; c++) begin
      if (cv[c]) begin
        t = int'(ct[c*TAG_W +: TAG_W]);
        foreach (mq[j]) begin
          if (mq[j].tag == t && !mq[j].done) begin
            mq[j].done = 1'b1;
            mq[j].rdy  = cyc + 2;
          end
        end
      end
    end
    if (mp) begin
      pos = -1;
      foreach (mq[j]) if (mq[j].tag == mt) pos = j;
      if (pos >= 0 && pos != mq.size() - 1) begin
        while (mq.size() > pos + 1) void'(mq.pop_back());
        m_tail = (mt + 1) % DEPTH;
      end
    end
    if (av && rdy) begin
      chk("alloc_tag", int'(rob_if.alloc_tag), m_tail);
      mq.push_back('{tag: m_tail, pd: pd, hrd: int'(hrd), done: 1'b0, rdy: 0});
      m_tail = (m_tail + 1) % DEPTH;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 3'b000, 12'h000, 1'b0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && mq.size() > 0; i++) idle();
    chk("drain_empty", mq.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int   issued;
    logic [2:0]  cv;
    logic [11:0] ct;
    rst                   = 1'b0;
    rob_if.alloc_valid    = 1'b0;
    rob_if.alloc_has_rd   = 1'b0;
    rob_if.alloc_pd_old   = '0;
    rob_if.cmpl_valid     = '0;
    rob_if.cmpl_tag       = '0;
    rob_if.mispredict     = 1'b0;
    rob_if.mispredict_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Reset state
    chk("rst_count", int'(rob_if.count), 0);
    chk("rst_empty", int'(rob_if.empty), 1);
    chk("rst_alloc_ready", int'(rob_if.alloc_ready), 1);
    chk("rst_alloc_tag", int'(rob_if.alloc_tag), 0);
    chk("rst_retire_valid", int'(rob_if.retire_valid), 0);

    // Fill to full, extra alloc ignored, single completion retires one cycle later
    for (int i = 0; i < 16; i++) step(1'b1, i[0], 'h10 + i, 3'b000, 12'h000, 1'b0, 0);
    chk("full_count", int'(rob_if.count), 16);
    chk("full_alloc_ready", int'(rob_if.alloc_ready), 0);
    step(1'b1, 1'b1, 'h7f, 3'b000, 12'h000, 1'b0, 0);
    chk("full_count_after_17th", int'(rob_if.count), 16);
    step(1'b0, 1'b0, 0, 3'b001, pk(0, 0, 0), 1'b0, 0);
    chk("c0_no_early_retire", int'(rob_if.retire_valid), 0);
    idle();
    chk("c0_retire_valid", int'(rob_if.retire_valid), 1);
    chk("c0_retire_tag", int'(rob_if.retire_tag[3:0]), 0);
    chk("c0_count", int'(rob_if.count), 15);
    for (int t = 1; t < 16; t += 3) step(1'b0, 1'b0, 0, 3'b111, pk(t, t + 1, t + 2), 1'b0, 0);
    drain();

    // Out-of-order completion across channels, in-order two-wide retirement
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 'h30 + i, 3'b000, 12'h000, 1'b0, 0);
    step(1'b0, 1'b0, 0, 3'b111, pk(3, 2, 1), 1'b0, 0);
    step(1'b0, 1'b0, 0, 3'b001, pk(0, 0, 0), 1'b0, 0);
    chk("ooo_blocked_by_head", int'(rob_if.retire_valid), 0);
    idle();
    chk("ooo_first_valid", int'(rob_if.retire_valid), 3);
    chk("ooo_first_tags", int'(rob_if.retire_tag), 'h10);
    idle();
    chk("ooo_second_valid", int'(rob_if.retire_valid), 3);
    chk("ooo_second_tags", int'(rob_if.retire_tag), 'h32);
    chk("ooo_count", int'(rob_if.count), 0);

    // Payload carried to retirement for exactly one cycle
    step(1'b1, 1'b1, 'h25, 3'b000, 12'h000, 1'b0, 0);
    step(1'b0, 1'b0, 0, 3'b001, pk(4, 0, 0), 1'b0, 0);
    idle();
    chk("pd_retire_valid", int'(rob_if.retire_valid), 1);
    chk("pd_retire_pd_old", int'(rob_if.retire_pd_old[6:0]), 'h25);
    chk("pd_retire_has_rd", int'(rob_if.retire_has_rd[0]), 1);
    idle();
    chk("pd_retire_once", int'(rob_if.retire_valid), 0);

    // Continuous stream across pointer wrap
    issued = 0;
    for (int i = 0; i < 60; i++) begin
      cv = 3'b000;
      ct = 12'h000;
      for (int j = 0; j < mq.size(); j++) begin
        if (!mq[j].done) begin
          cv = 3'b001;
          ct = pk(mq[j].tag, 0, 0);
          break;
        end
      end
      step(issued < 40, i[1], 'h40 + (i % 32), cv, ct, 1'b0, 0);
      if (issued < 40) issued++;
    end
    drain();

    // Reset with entries, partial completions, concurrent alloc and mispredict
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 'h60 + i, 3'b000, 12'h000, 1'b0, 0);
    step(1'b0, 1'b0, 0, 3'b011, pk(15, 0, 0), 1'b0, 0);
    idle();
    chk("pre_reset_count", int'(rob_if.count), 5);
    rst                   = 1'b0;
    rob_if.alloc_valid    = 1'b1;
    rob_if.cmpl_valid     = 3'b001;
    rob_if.cmpl_tag       = pk(13, 0, 0);
    rob_if.mispredict     = 1'b1;
    rob_if.mispredict_tag = 4'd14;
    mq.delete();
    m_tail = 0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    chk("mid_reset_count", int'(rob_if.count), 0);
    chk("mid_reset_empty", int'(rob_if.empty), 1);
    chk("mid_reset_retire_valid", int'(rob_if.retire_valid), 0);
    idle();

    // Mispredict truncation, ignored completion/mispredicts, re-alloc of flushed tags
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 'h40 + i, 3'b000, 12'h000, 1'b0, 0);
    step(1'b0, 1'b0, 0, 3'b001, pk(6, 0, 0), 1'b1, 3);
    chk("flush_count", int'(rob_if.count), 4);
    chk("flush_alloc_tag", int'(rob_if.alloc_tag), 4);
    step(1'b0, 1'b0, 0, 3'b000, 12'h000, 1'b1, 9);
    chk("flush_invalid_tag_count", int'(rob_if.count), 4);
    step(1'b0, 1'b0, 0, 3'b000, 12'h000, 1'b1, 3);
    chk("flush_last_tag_count", int'(rob_if.count), 4);
    step(1'b1, 1'b1, 'h54, 3'b000, 12'h000, 1'b0, 0);
    step(1'b1, 1'b1, 'h55, 3'b000, 12'h000, 1'b0, 0);
    step(1'b0, 1'b0, 0, 3'b111, pk(0, 1, 2), 1'b0, 0);
    step(1'b0, 1'b0, 0, 3'b111, pk(3, 4, 5), 1'b0, 0);
    drain();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
